// File: rtl/i2c_master_if.sv
// Command/response handshake and open-drain pin bundle for i2c_master.
// The master modport is the i2c_master view; the slave modport is the command issuer / bus side.
interface i2c_master_if;
  logic       start_req;
  logic       rd_nwr;
  logic [6:0] slave_id;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;

  modport master (
    input  start_req, rd_nwr, slave_id, reg_addr, wdata, sda_in,
    output busy, done, ack_err, rdata, scl_out, sda_out
  );

  modport slave (
    output start_req, rd_nwr, slave_id, reg_addr, wdata, sda_in,
    input  busy, done, ack_err, rdata, scl_out, sda_out
  );
endinterface

// File: rtl/i2c_master.sv
// Single-byte register-access I2C master: one write (ID+W, addr, data) or read
// (ID+W, addr, Sr, ID+R, data, NACK) transaction per start_req.
module i2c_master #(
  parameter int unsigned CLK_DIV = 62  // clk cycles per quarter SCL period, legal 2..1023
) (
  input  logic         clk,
  input  logic         rst,
  i2c_master_if.master bus_io
);

  typedef enum logic [3:0] {
    StIdle, StStart, StTxByte, StRxAck, StRstart, StRxByte, StTxNack, StStop, StDone
  } state_e;

  localparam logic [9:0] QuarterLast = 10'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [9:0] qcnt_q, qcnt_d;
  logic [1:0] quarter_q, quarter_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rd_q, rd_d;
  logic [6:0] id_q, id_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       sda_dly_q;
  logic [1:0] sda_sync_q;

  logic q_end, bit_end, sample;

  assign q_end   = (qcnt_q == QuarterLast);
  assign sample  = q_end && (quarter_q == 2'd2);
  assign bit_end = q_end && (quarter_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    quarter_d  = quarter_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rd_d       = rd_q;
    id_d       = id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_err_d  = ack_err_q;
    rdata_d    = rdata_q;

    if (state_q != StIdle && state_q != StDone) begin
      qcnt_d = q_end ? 10'd0 : qcnt_q + 10'd1;
      if (q_end) quarter_d = quarter_q + 2'd1;
    end else begin
      qcnt_d    = 10'd0;
      quarter_d = 2'd0;
    end

    // ACK slots and data bits share the receive shifter; bit 0 holds the latest ACK.
    if ((state_q == StRxAck || state_q == StRxByte) && sample) begin
      rx_sh_d = {rx_sh_q[6:0], sda_sync_q[1]};
    end

    unique case (state_q)
      StIdle: begin
        if (bus_io.start_req) begin
          rd_d       = bus_io.rd_nwr;
          id_d       = bus_io.slave_id;
          addr_d     = bus_io.reg_addr;
          wdata_d    = bus_io.wdata;
          tx_sh_d    = {bus_io.slave_id, 1'b0};
          ack_err_d  = 1'b0;
          bit_cnt_d  = 4'd0;
          byte_idx_d = 2'd0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StTxByte;
      end
      StTxByte: begin
        if (bit_end) begin
          tx_sh_d   = {tx_sh_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            state_d   = StRxAck;
          end
        end
      end
      StRxAck: begin
        if (bit_end) begin
          if (rx_sh_q[0]) begin
            ack_err_d = 1'b1;
            state_d   = StStop;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            unique case (byte_idx_q)
              2'd0: begin
                tx_sh_d = addr_q;
                state_d = StTxByte;
              end
              2'd1: begin
                if (rd_q) begin
                  state_d = StRstart;
                end else begin
                  tx_sh_d = wdata_q;
                  state_d = StTxByte;
                end
              end
              default: state_d = rd_q ? StRxByte : StStop;
            endcase
          end
        end
      end
      StRstart: begin
        if (bit_end) begin
          tx_sh_d = {id_q, 1'b1};
          state_d = StTxByte;
        end
      end
      StRxByte: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            rdata_d   = rx_sh_q;
            state_d   = StTxNack;
          end
        end
      end
      StTxNack: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Line levels per quarter; both are re-timed below so SDA lags SCL edges by one clk.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    unique case (state_q)
      StStart: begin
        scl_d = (quarter_q != 2'd3);
        sda_d = (quarter_q < 2'd2);
      end
      StTxByte: begin
        scl_d = quarter_q[1];
        sda_d = tx_sh_q[7];
      end
      StRxAck, StRxByte, StTxNack: begin
        scl_d = quarter_q[1];
        sda_d = 1'b1;
      end
      StRstart: begin
        scl_d = (quarter_q == 2'd1) || (quarter_q == 2'd2);
        sda_d = (quarter_q < 2'd2);
      end
      StStop: begin
        scl_d = (quarter_q != 2'd0);
        sda_d = (quarter_q == 2'd3);
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  assign busy_d = (state_d != StIdle) && (state_d != StDone);
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      qcnt_q     <= 10'd0;
      quarter_q  <= 2'd0;
      bit_cnt_q  <= 4'd0;
      byte_idx_q <= 2'd0;
      tx_sh_q    <= 8'hFF;
      rx_sh_q    <= 8'h00;
      rd_q       <= 1'b0;
      id_q       <= 7'h00;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      ack_err_q  <= 1'b0;
      rdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      sda_dly_q  <= 1'b1;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      quarter_q  <= quarter_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rd_q       <= rd_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_err_q  <= ack_err_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      sda_dly_q  <= sda_q;
      sda_sync_q <= {sda_sync_q[0], bus_io.sda_in};
    end
  end

  assign bus_io.busy    = busy_q;
  assign bus_io.done    = done_q;
  assign bus_io.ack_err = ack_err_q;
  assign bus_io.rdata   = rdata_q;
  assign bus_io.scl_out = scl_q;
  assign bus_io.sda_out = sda_dly_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master against a behavioural regmap slave on a wired-AND bus,
// with a bus monitor tracking SCL high-phase widths, START/STOP events and done pulses.
module tb_i2c_master;

  localparam int unsigned DIV = 4;
  localparam logic [6:0] SlaveId = 7'h24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_master_if bus ();

  logic sl_drv = 1'b1;
  wire  scl_bus = bus.scl_out;
  wire  sda_bus = bus.sda_out & sl_drv;
  assign bus.sda_in = sda_bus;

  i2c_master #(.CLK_DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave model and monitor state, written only by the block below.
  logic [7:0] sl_mem [256];
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_ptr = 8'h00;
  int   sl_bits = 0;
  int   sl_byte = 0;
  bit   sl_sel = 0, sl_tx = 0, sl_after = 0, sl_pend = 0;
  int   n_starts = 0, n_stops = 0, n_nacks = 0, wr_cnt = 0, done_cnt = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
  int   sda_hi_changes = 0, hi_bad = 0, hi_phases = 0, hi_len = 0;
  bit   hi_valid = 0;
  logic pc = 1'b1, ps = 1'b1;

  always @(negedge clk) begin
    logic c, s;
    c = scl_bus;
    s = sda_bus;
    if (c && pc && (s != ps)) sda_hi_changes++;
    if (rst || !bus.busy) begin
      hi_valid = 0;
    end else if (c && !pc) begin
      hi_valid = 1;
      hi_len = 1;
    end else if (c && hi_valid) begin
      hi_len++;
    end else if (!c && pc && hi_valid) begin
      if (hi_len != 2 * DIV) hi_bad++;
      hi_phases++;
      hi_valid = 0;
    end
    if (bus.done) done_cnt++;

    if (c && pc && ps && !s) begin
      n_starts++;
      sl_sel = 1; sl_bits = 0; sl_byte = 0; sl_tx = 0; sl_after = 0; sl_pend = 0; sl_drv = 1'b1;
    end else if (c && pc && !ps && s) begin
      n_stops++;
      sl_sel = 0; sl_drv = 1'b1;
    end else if (sl_sel && c && !pc) begin
      if (sl_bits < 8) begin
        if (!sl_tx) sl_sh = {sl_sh[6:0], s};
        sl_bits++;
      end else begin
        if (sl_tx) begin
          if (s) n_nacks++;
          sl_tx = 0; sl_sel = 0; sl_ptr = sl_ptr + 8'd1;
        end
        sl_bits = 0;
        sl_after = 1;
      end
    end else if (sl_sel && !c && pc) begin
      if (sl_after) begin
        sl_after = 0;
        sl_drv = 1'b1;
        if (sl_pend) begin
          sl_pend = 0; sl_tx = 1; sl_sh = sl_mem[sl_ptr]; sl_drv = sl_sh[7];
        end
      end else if (sl_tx) begin
        if (sl_bits < 8) begin
          sl_sh = {sl_sh[6:0], 1'b0};
          sl_drv = sl_sh[7];
        end else begin
          sl_drv = 1'b1;
        end
      end else if (sl_bits == 8) begin
        if (sl_byte == 0) begin
          if (sl_sh[7:1] == SlaveId) begin
            sl_drv = 1'b0; sl_pend = sl_sh[0];
          end else begin
            sl_sel = 0;
          end
        end else if (sl_byte == 1) begin
          sl_ptr = sl_sh; sl_drv = 1'b0;
        end else begin
          sl_mem[sl_ptr] = sl_sh; wr_cnt++; wr_addr = sl_ptr; wr_data = sl_sh;
          sl_ptr = sl_ptr + 8'd1; sl_drv = 1'b0;
        end
        sl_byte++;
      end
    end
    pc = c;
    ps = s;
  end

  task automatic send_cmd(input logic rd, input logic [6:0] id, input logic [7:0] a,
                          input logic [7:0] d);
    bus.rd_nwr = rd; bus.slave_id = id; bus.reg_addr = a; bus.wdata = d; bus.start_req = 1'b1;
    @(posedge clk); #1;
    bus.start_req = 1'b0;
  endtask

  // Returns the cycle count of done, counting the edge that sampled start_req as 1.
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.scl_out !== 1'b1) begin errors++; $display("FAIL rst_scl got %b want 1", bus.scl_out); end
    checks++; if (bus.sda_out !== 1'b1) begin errors++; $display("FAIL rst_sda got %b want 1", bus.sda_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.done); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got %b want 0", bus.ack_err); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", bus.rdata); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_write;
    int n, w0, s0, p0, c0, b0, st0, sp0;
    w0 = wr_cnt; s0 = sda_hi_changes; p0 = hi_phases; b0 = hi_bad; st0 = n_starts; sp0 = n_stops;
    send_cmd(1'b0, 7'h24, 8'h10, 8'h5A);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", bus.busy); end
    wait_done(n);
    checks++; if (n != 465) begin errors++; $display("FAIL wr_latency got %0d want 465", n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done got %b want 0", bus.busy); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err got %b want 0", bus.ack_err); end
    repeat (4) @(posedge clk);
    #1;
    c0 = wr_cnt - w0;
    checks++; if (c0 != 1) begin errors++; $display("FAIL wr_count got %0d want 1", c0); end
    checks++; if (wr_addr !== 8'h10) begin errors++; $display("FAIL wr_addr got %h want 10", wr_addr); end
    checks++; if (wr_data !== 8'h5A) begin errors++; $display("FAIL wr_data got %h want 5a", wr_data); end
    checks++; if (sda_hi_changes - s0 != 2) begin errors++; $display("FAIL wr_sda_hi got %0d want 2", sda_hi_changes - s0); end
    checks++; if (hi_phases - p0 != 27) begin errors++; $display("FAIL wr_scl_phases got %0d want 27", hi_phases - p0); end
    checks++; if (hi_bad != b0) begin errors++; $display("FAIL wr_scl_width got %0d want 0 bad", hi_bad - b0); end
    checks++; if (n_starts - st0 != 1 || n_stops - sp0 != 1) begin
      errors++; $display("FAIL wr_start_stop got %0d/%0d want 1/1", n_starts - st0, n_stops - sp0);
    end
  endtask

  task automatic test_read;
    int n, s0, p0, b0, st0, k0;
    s0 = sda_hi_changes; p0 = hi_phases; b0 = hi_bad; st0 = n_starts; k0 = n_nacks;
    send_cmd(1'b1, 7'h24, 8'h10, 8'h00);
    wait_done(n);
    checks++; if (n != 625) begin errors++; $display("FAIL rd_latency got %0d want 625", n); end
    checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL rd_data got %h want 5a", bus.rdata); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err got %b want 0", bus.ack_err); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (n_starts - st0 != 2) begin errors++; $display("FAIL rd_starts got %0d want 2", n_starts - st0); end
    checks++; if (n_nacks - k0 != 1) begin errors++; $display("FAIL rd_master_nack got %0d want 1", n_nacks - k0); end
    checks++; if (sda_hi_changes - s0 != 3) begin errors++; $display("FAIL rd_sda_hi got %0d want 3", sda_hi_changes - s0); end
    checks++; if (hi_phases - p0 != 37) begin errors++; $display("FAIL rd_scl_phases got %0d want 37", hi_phases - p0); end
    checks++; if (hi_bad != b0) begin errors++; $display("FAIL rd_scl_width got %0d want 0 bad", hi_bad - b0); end
  endtask

  task automatic test_wrong_id;
    int n, w0, sp0, p0;
    w0 = wr_cnt; sp0 = n_stops; p0 = hi_phases;
    send_cmd(1'b0, 7'h25, 8'h10, 8'hEE);
    wait_done(n);
    checks++; if (n != 177) begin errors++; $display("FAIL nack_latency got %0d want 177", n); end
    checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b want 1", bus.ack_err); end
    checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL nack_rdata got %h want 5a", bus.rdata); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err_hold got %b want 1", bus.ack_err); end
    checks++; if (n_stops - sp0 != 1) begin errors++; $display("FAIL nack_stop got %0d want 1", n_stops - sp0); end
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL nack_writes got %0d want 0", wr_cnt - w0); end
    checks++; if (hi_phases - p0 != 9) begin errors++; $display("FAIL nack_scl_phases got %0d want 9", hi_phases - p0); end
  endtask

  task automatic test_busy_reject;
    int n, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(1'b0, 7'h24, 8'h20, 8'hC3);
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL busy_ack_err_clr got %b want 0", bus.ack_err); end
    n = 1;
    while (!bus.done && n < 3000) begin
      if (n == 50) begin
        bus.rd_nwr = 1'b0; bus.slave_id = 7'h24; bus.reg_addr = 8'h30; bus.wdata = 8'h77;
        bus.start_req = 1'b1;
      end else begin
        bus.start_req = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start_req = 1'b0;
    checks++; if (n != 465) begin errors++; $display("FAIL busy_latency got %0d want 465", n); end
    repeat (600) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL busy_writes got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr !== 8'h20 || wr_data !== 8'hC3) begin
      errors++; $display("FAIL busy_write_content got %h/%h want 20/c3", wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_mid;
    int n, w0;
    w0 = wr_cnt;
    send_cmd(1'b0, 7'h24, 8'h40, 8'h11);
    repeat (199) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.scl_out !== 1'b1) begin errors++; $display("FAIL midrst_scl got %b want 1", bus.scl_out); end
    checks++; if (bus.sda_out !== 1'b1) begin errors++; $display("FAIL midrst_sda got %b want 1", bus.sda_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata got %h want 00", bus.rdata); end
    repeat (10) @(posedge clk);
    #1;
    send_cmd(1'b0, 7'h24, 8'h41, 8'h99);
    wait_done(n);
    checks++; if (n != 465) begin errors++; $display("FAIL midrst_latency got %0d want 465", n); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL midrst_ack_err got %b want 0", bus.ack_err); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL midrst_writes got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr !== 8'h41 || wr_data !== 8'h99) begin
      errors++; $display("FAIL midrst_write_content got %h/%h want 41/99", wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    send_cmd(1'b1, 7'h24, 8'h41, 8'h00);
    wait_done(n);
    checks++; if (n != 625) begin errors++; $display("FAIL b2b_latency got %0d want 625", n); end
    checks++; if (bus.rdata !== 8'h99) begin errors++; $display("FAIL b2b_rdata got %h want 99", bus.rdata); end
  endtask

  initial begin
    bus.start_req = 1'b0;
    bus.rd_nwr    = 1'b0;
    bus.slave_id  = 7'h00;
    bus.reg_addr  = 8'h00;
    bus.wdata     = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_wrong_id();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
